// File: rtl/bus_memory_slave.sv
`timescale 1ns/1ps
// bus_memory_slave: bus responder with a 512-word memory behind a 2 KiB window.
// Accepts single/burst writes with byte enables, returns single/burst reads,
// and pulses errorOUT for accesses that miss the window.
// Ports:
//   clock, reset (sync, active-low)
//   address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
//   begin_transactionIN, end_transactionIN, data_validIN, busyIN  - from master
//   address_dataOUT, data_validOUT, end_transactionOUT, busyOUT,
//   errorOUT                                                       - to master
//   s_slave_cur_state                                              - debug state
module bus_memory_slave #(
  parameter logic [31:0] Base = 32'h4000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dataIN,
  input  logic [3:0]  byte_enableIN,
  input  logic [7:0]  burst_sizeIN,
  input  logic        read_n_writeIN,
  input  logic        begin_transactionIN,
  input  logic        end_transactionIN,
  input  logic        data_validIN,
  input  logic        busyIN,
  output logic [31:0] address_dataOUT,
  output logic        data_validOUT,
  output logic        end_transactionOUT,
  output logic        busyOUT,
  output logic        errorOUT,
  output logic [2:0]  s_slave_cur_state
);

  localparam int unsigned WordCount = 512;
  localparam int unsigned IdxW      = 9;
  localparam int unsigned CntW      = 9;
  localparam logic [20:0] BaseTag   = Base[31:11];

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    READ_FETCH = 3'd2,
    READ_DATA  = 3'd3,
    READ_END   = 3'd4,
    ERROR      = 3'd5
  } state_t;

  state_t            state, next_state;
  logic [IdxW-1:0]   idx, next_idx;
  logic [CntW-1:0]   beats_left, next_beats;
  logic [3:0]        be, next_be;
  logic [31:0]       mem [WordCount];

  logic              hit_c;
  logic              wr_beat_c;
  logic [IdxW-1:0]   rd_addr_c;

  assign hit_c   = (address_dataIN[31:11] == BaseTag);
  assign busyOUT = 1'b0;
  assign s_slave_cur_state = state;

  // Next-state, index/counter update, write strobe and RAM read address.
  // beats_left underflows to bit 8 set once the burst is exhausted.
  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_beats = beats_left;
    next_be    = be;
    wr_beat_c  = 1'b0;
    rd_addr_c  = idx;
    case (state)
      IDLE: begin
        if (begin_transactionIN) begin
          next_idx   = address_dataIN[10:2];
          next_be    = byte_enableIN;
          next_beats = CntW'(burst_sizeIN);
          if (!hit_c)              next_state = ERROR;
          else if (read_n_writeIN) next_state = READ_FETCH;
          else                     next_state = WRITE;
        end
      end
      WRITE: begin
        if (data_validIN && !beats_left[CntW-1]) begin
          wr_beat_c  = 1'b1;
          next_idx   = idx + IdxW'(1);
          next_beats = beats_left - CntW'(1);
        end
        if (end_transactionIN) next_state = IDLE;
      end
      READ_FETCH: begin
        next_state = end_transactionIN ? IDLE : READ_DATA;
      end
      READ_DATA: begin
        if (end_transactionIN) begin
          next_state = IDLE;
        end else if (!busyIN) begin
          next_idx   = idx + IdxW'(1);
          next_beats = beats_left - CntW'(1);
          rd_addr_c  = idx + IdxW'(1);
          if (beats_left == '0) next_state = READ_END;
        end
      end
      READ_END: next_state = IDLE;
      ERROR:    next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // State, transaction context and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state              <= IDLE;
      idx                <= '0;
      beats_left         <= '0;
      be                 <= '0;
      address_dataOUT    <= '0;
      data_validOUT      <= 1'b0;
      end_transactionOUT <= 1'b0;
      errorOUT           <= 1'b0;
    end else begin
      state              <= next_state;
      idx                <= next_idx;
      beats_left         <= next_beats;
      be                 <= next_be;
      address_dataOUT    <= (next_state == READ_DATA) ? mem[rd_addr_c] : '0;
      data_validOUT      <= (next_state == READ_DATA);
      end_transactionOUT <= (next_state == READ_END);
      errorOUT           <= (next_state == ERROR);
    end
  end

  // Byte-lane write port; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (reset && wr_beat_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= address_dataIN[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bus_memory_slave.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for bus_memory_slave with a word-array model.
module tb_bus_memory_slave;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_dataIN = '0;
  logic [3:0]  byte_enableIN = '0;
  logic [7:0]  burst_sizeIN = '0;
  logic        read_n_writeIN = 1'b0;
  logic        begin_transactionIN = 1'b0;
  logic        end_transactionIN = 1'b0;
  logic        data_validIN = 1'b0;
  logic        busyIN = 1'b0;
  logic [31:0] address_dataOUT;
  logic        data_validOUT;
  logic        end_transactionOUT;
  logic        busyOUT;
  logic        errorOUT;
  logic [2:0]  s_slave_cur_state;

  bus_memory_slave #(.Base(BASE)) dut (
    .clock(clock), .reset(reset),
    .address_dataIN(address_dataIN), .byte_enableIN(byte_enableIN),
    .burst_sizeIN(burst_sizeIN), .read_n_writeIN(read_n_writeIN),
    .begin_transactionIN(begin_transactionIN), .end_transactionIN(end_transactionIN),
    .data_validIN(data_validIN), .busyIN(busyIN),
    .address_dataOUT(address_dataOUT), .data_validOUT(data_validOUT),
    .end_transactionOUT(end_transactionOUT), .busyOUT(busyOUT),
    .errorOUT(errorOUT), .s_slave_cur_state(s_slave_cur_state)
  );

  always #5 clock = ~clock;

  typedef struct { int cyc; logic [31:0] data; } beat_t;

  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  bit          mon_on = 1'b0;
  logic [31:0] ref_mem [512];
  beat_t       beat_q [$];
  int          end_q [$];
  int          err_q [$];
  logic [31:0] wbuf [$];
  int          stalls [$];
  beat_t       mon_b;
  int          mon_c;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cycle %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] hit_addr(input int unsigned idx);
    logic [1:0] lo = 2'($urandom);
    return {BASE[31:11], 9'(idx), lo};
  endfunction

  task automatic set_idle();
    begin_transactionIN = 1'b0;
    end_transactionIN   = 1'b0;
    data_validIN        = 1'b0;
    busyIN              = 1'b0;
    read_n_writeIN      = 1'($urandom);
    byte_enableIN       = 4'($urandom);
    burst_sizeIN        = 8'($urandom);
    address_dataIN      = $urandom;
  endtask

  // Write: sends every word in wbuf; the model keeps only the first burst+1.
  task automatic do_write(input int unsigned idx, input int burst, input logic [3:0] be,
                          input bit gaps);
    int n = wbuf.size();
    @(negedge clock); set_idle();
    begin_transactionIN = 1'b1; address_dataIN = hit_addr(idx);
    byte_enableIN = be; burst_sizeIN = 8'(burst); read_n_writeIN = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin @(negedge clock); set_idle(); end
      @(negedge clock); set_idle();
      data_validIN = 1'b1; address_dataIN = wbuf[i]; end_transactionIN = (i == n - 1);
      if (i <= burst) ref_mem[(idx + i) % 512] = merge(ref_mem[(idx + i) % 512], wbuf[i], be);
    end
  endtask

  // Read: stalls[j] busy cycles on beat j; abort_at >= 0 aborts on that beat;
  // reset_at >= 0 pulses reset on that beat.
  task automatic do_read(input int unsigned idx, input int burst, input int abort_at,
                         input int reset_at);
    @(negedge clock); set_idle();
    begin_transactionIN = 1'b1; address_dataIN = hit_addr(idx);
    burst_sizeIN = 8'(burst); read_n_writeIN = 1'b1;
    @(negedge clock); set_idle();
    chk("fetch_state", 32'(s_slave_cur_state), 32'd2);
    for (int j = 0; j <= burst; j++) begin
      int st = (j < stalls.size()) ? stalls[j] : 0;
      for (int s = 0; s <= st; s++) begin
        @(negedge clock); set_idle();
        beat_q.push_back('{cyc: cyc, data: ref_mem[(idx + j) % 512]});
        if (j == abort_at) begin
          end_transactionIN = 1'b1;
          return;
        end
        if (j == reset_at) begin
          reset = 1'b0;
          @(negedge clock); set_idle();
          reset = 1'b1;
          chk("rst_state", 32'(s_slave_cur_state), 32'd0);
          chk("rst_outs", {address_dataOUT[27:0], data_validOUT, end_transactionOUT,
                           errorOUT, busyOUT}, 32'd0);
          chk("rst_data", address_dataOUT, 32'd0);
          return;
        end
        busyIN = (s < st);
      end
    end
    @(negedge clock); set_idle();
    end_q.push_back(cyc);
  endtask

  task automatic do_miss(input logic [31:0] addr, input bit rnw);
    @(negedge clock); set_idle();
    begin_transactionIN = 1'b1; address_dataIN = addr; read_n_writeIN = rnw;
    err_q.push_back(cyc + 1);
    @(negedge clock); set_idle();
    data_validIN = ~rnw;
  endtask

  function automatic logic [31:0] miss_addr();
    logic [31:0] a = $urandom;
    while (a[31:11] == BASE[31:11]) a = $urandom;
    return a;
  endfunction

  // Monitor: pops expected beats/pulses whenever the DUT presents them.
  always @(negedge clock) begin
    if (mon_on) begin
      chk("busy_out", 32'(busyOUT), 32'd0);
      if (data_validOUT) begin
        if (beat_q.size() == 0) chk("beat_valid", 32'(data_validOUT), 32'd0);
        else begin
          mon_b = beat_q.pop_front();
          chk("beat_cycle", 32'(cyc), 32'(mon_b.cyc));
          chk("beat_data", address_dataOUT, mon_b.data);
        end
      end else begin
        chk("idle_data", address_dataOUT, 32'd0);
        if (beat_q.size() > 0 && beat_q[0].cyc <= cyc) begin
          chk("beat_valid", 32'(data_validOUT), 32'd1);
          mon_b = beat_q.pop_front();
        end
      end
      if (end_transactionOUT) begin
        if (end_q.size() == 0) chk("end_pulse", 32'(end_transactionOUT), 32'd0);
        else begin
          mon_c = end_q.pop_front();
          chk("end_cycle", 32'(cyc), 32'(mon_c));
        end
      end else if (end_q.size() > 0 && end_q[0] <= cyc) begin
        chk("end_pulse", 32'(end_transactionOUT), 32'd1);
        mon_c = end_q.pop_front();
      end
      if (errorOUT) begin
        if (err_q.size() == 0) chk("error_pulse", 32'(errorOUT), 32'd0);
        else begin
          mon_c = err_q.pop_front();
          chk("error_cycle", 32'(cyc), 32'(mon_c));
        end
      end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
        chk("error_pulse", 32'(errorOUT), 32'd1);
        mon_c = err_q.pop_front();
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_state", 32'(s_slave_cur_state), 32'd0);
    chk("reset_outs", {28'd0, data_validOUT, end_transactionOUT, errorOUT, busyOUT}, 32'd0);
    chk("reset_data", address_dataOUT, 32'd0);
    reset = 1'b1;
    mon_on = 1'b1;

    // Fill the whole memory so every later read has a known expectation.
    for (int h = 0; h < 2; h++) begin
      wbuf.delete();
      for (int i = 0; i < 256; i++) wbuf.push_back($urandom);
      do_write(h * 256, 255, 4'hF, 1'b0);
    end

    // Single write then read at Base+0x10.
    wbuf = '{32'hDEAD_BEEF};
    do_write(4, 0, 4'hF, 1'b0);
    stalls.delete();
    do_read(4, 0, -1, -1);

    // Byte-enable merge.
    wbuf = '{32'h1122_3344};
    do_write(8, 0, 4'hF, 1'b0);
    wbuf = '{32'hAABB_CCDD};
    do_write(8, 0, 4'b0101, 1'b0);
    do_read(8, 0, -1, -1);

    // Burst of 4 wrapping past word 511.
    wbuf = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_write(510, 3, 4'hF, 1'b0);
    do_read(510, 3, -1, -1);
    do_read(0, 1, -1, -1);

    // Stall the second beat of a 3-beat read for two cycles.
    stalls = '{0, 2, 0};
    do_read(20, 2, -1, -1);
    stalls.delete();

    // Miss followed immediately by a serviced read.
    do_miss(32'h4000_0800, 1'b1);
    do_read(4, 0, -1, -1);

    // Reset during READ_DATA, then a normal transaction.
    do_read(100, 5, -1, 2);
    do_read(100, 5, -1, -1);

    // Randomized mix.
    for (int t = 0; t < 300; t++) begin
      int kind  = $urandom_range(0, 99);
      int burst = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 7);
      int unsigned idx = $urandom_range(0, 511);
      if (kind < 40) begin
        wbuf.delete();
        for (int i = 0, n = $urandom_range(1, burst + 3); i < n; i++) wbuf.push_back($urandom);
        do_write(idx, burst, 4'($urandom), 1'b1);
      end else if (kind < 80) begin
        stalls.delete();
        for (int i = 0; i <= burst; i++)
          stalls.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        do_read(idx, burst, -1, -1);
        stalls.delete();
      end else if (kind < 90) begin
        do_miss(miss_addr(), 1'($urandom));
      end else if (kind < 95) begin
        do_read(idx, burst, $urandom_range(0, burst), -1);
      end else begin
        do_read(idx, burst, -1, $urandom_range(0, burst));
      end
    end

    @(negedge clock); set_idle();
    repeat (6) @(negedge clock);
    chk("beats_left_over", 32'(beat_q.size()), 32'd0);
    chk("ends_left_over", 32'(end_q.size()), 32'd0);
    chk("errors_left_over", 32'(err_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bus_memory_slave.md
# bus_memory_slave

Bus responder holding a 512-word on-chip memory, the target-side counterpart of the JTAG DMA bus initiator. It decodes begin-transaction cycles against its address window and accepts single or burst writes with byte enables. It returns single or burst reads and signals an error for out-of-window accesses. It sits on the shared Gecko5 bus behind the arbiter and gives the DMA a known-good target for bring-up and loopback.

## Interface
- Base, 32'h40000000, byte base address of the 2 KiB window; only Base[31:11] is used.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- address_dataIN  in  32  address on the begin cycle, write data on data beats.
- byte_enableIN  in  4  lane enables, sampled on the begin cycle.
- burst_sizeIN  in  8  beats minus one, sampled on the begin cycle.
- read_n_writeIN  in  1  1 = read, 0 = write, sampled on the begin cycle.
- begin_transactionIN  in  1  one-cycle transaction start.
- end_transactionIN  in  1  master ends a write, or aborts a read.
- data_validIN  in  1  write beat present.
- busyIN  in  1  master stall during read beats.
- address_dataOUT  out  32  read data; 0 when data_validOUT = 0.
- data_validOUT  out  1  read beat present.
- end_transactionOUT  out  1  one-cycle pulse after the last read beat.
- busyOUT  out  1  slave stall; tied 0 in this revision.
- errorOUT  out  1  one-cycle address-miss pulse.
- s_slave_cur_state  out  3  current FSM state, for debug.

## Operation
- States:
  - IDLE=0.
  - WRITE=1.
  - READ_FETCH=2.
  - READ_DATA=3.
  - READ_END=4.
  - ERROR=5.
- Begin cycle, IDLE with begin_transactionIN=1:
  - Hit when address_dataIN[31:11] == Base[31:11].
  - Capture word index idx = address_dataIN[10:2], byte enables be, and beats_left = burst_sizeIN (9-bit counter).
  - Hit and write: go to WRITE. Hit and read: go to READ_FETCH. Miss: go to ERROR.
- begin_transactionIN outside IDLE is ignored.
- WRITE:
  - Each cycle with data_validIN=1 and beats_left not exhausted, write address_dataIN to mem[idx], updating only the lanes where be[i]=1.
  - Then idx <= idx+1 (mod 512) and decrement beats_left.
  - Beats beyond burst_size+1 are discarded.
  - end_transactionIN=1 returns to IDLE. A beat in that same cycle is still written.
- READ_FETCH: issue the synchronous RAM read for mem[idx]; go to READ_DATA next cycle.
- READ_DATA:
  - data_validOUT=1; address_dataOUT = mem[idx], all 32 bits regardless of be.
  - Beat accepted when busyIN=0. On accept: idx+1 (mod 512) and decrement beats_left; the RAM read address is idx+1 so the next beat is ready next cycle.
  - Last beat accepted: go to READ_END.
  - busyIN=1: hold the same data and state.
- READ_END: end_transactionOUT=1, data_validOUT=0; go to IDLE.
- ERROR: errorOUT=1 for one cycle; go to IDLE. Memory is not touched.
- end_transactionIN=1 in READ_FETCH or READ_DATA is a master abort: go to IDLE next cycle, with no end_transactionOUT.
- Memory contents are not reset.

## Timing
- Reset (reset=0 at a clock edge):
  - State goes to IDLE; all outputs are 0 from the following cycle.
  - Mid-transaction reset abandons the transaction. Words already written stay written.
- Write: a beat presented in cycle N is readable by a read that begins in N+1 or later. No write-side wait states, because busyOUT=0.
- Read, with begin in cycle T:
  - T+1 is READ_FETCH.
  - The first data_validOUT is in T+2.
  - With busyIN=0 throughout, beats fill T+2 .. T+2+burst_size, and end_transactionOUT is in T+3+burst_size.
  - Each busyIN=1 cycle extends this by one cycle.
- Miss: errorOUT in T+1; IDLE in T+2; a new begin is accepted in T+2.
- After READ_END or a write end, a new begin is accepted in the next cycle.
- A burst crossing word 511 wraps to word 0.

## Test plan
- Single write then read at Base+0x10:
  - Write 0xDEADBEEF with be=4'hF.
  - The read shows data_validOUT=1 at T+2 with 0xDEADBEEF, and end_transactionOUT at T+3.
- Byte-enable write:
  - Preload 0x11223344; write 0xAABBCCDD with be=4'b0101.
  - Read returns 0x11BB33DD.
- Burst of 4 at word 510:
  - Write 1,2,3,4 (burst_size=3).
  - A burst read from word 510 returns 1,2,3,4, confirming wrap; words 510,511,0,1 are correct.
- Read stall:
  - Burst read of 3 beats with busyIN=1 on the second beat for 2 cycles.
  - The second beat is held for 3 cycles, no beat is skipped or repeated, and end_transactionOUT comes 2 cycles later than the unstalled case.
- Address miss:
  - Begin read at 0x40000800.
  - errorOUT=1 in T+1 only, no data_validOUT, memory unchanged; a subsequent begin at T+2 is serviced.
- Reset mid-burst:
  - Assert reset=0 during READ_DATA.
  - Next cycle: state 0, all outputs 0. A following hit transaction completes normally.
